// File: rtl/result_writer_if.sv
// result_writer_if: result handshake and output-memory write port bundle.
// slave  : the result writer (consumes results, drives the memory write port)
// master : the producer / memory side (testbench or surrounding system)
interface result_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_ready;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    input  mem_ready,
    output in_ready,
    output wen,
    output waddr,
    output wdata
  );

  modport master (
    output in_valid,
    output in_data,
    output mem_ready,
    input  in_ready,
    input  wen,
    input  waddr,
    input  wdata
  );
endinterface

// File: rtl/result_writer.sv
// result_writer: buffers filter results in a small FIFO and writes them to the
// 128x128 output image in raster order (addr = {row, col}), then pulses done.
// Optional build macro RESULT_WRITER_BORDER_ZERO_EN: pixels on row 0/127 or
// col 0/127 are written as zero (input still consumed and counted).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; no results accepted
// S_RUN   | accepting results while the FIFO has room, writing head out
// S_DRAIN | all pixels accepted; flushing the remaining FIFO entries
// S_DONE  | single-cycle done pulse, returns to S_IDLE
module result_writer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  result_writer_if.slave        bus,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Accept / write counters wrap at the frame size; the terminal flags
  // remember that the wrap happened so a full frame is distinguishable from 0.
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              acc_term_q, acc_term_d;
  logic              wr_term_q, wr_term_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              active;
  logic              in_ready_c;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

`ifdef RESULT_WRITER_BORDER_ZERO_EN
  localparam int COL_W = ADDR_W / 2;
  localparam int ROW_W = ADDR_W - COL_W;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             border;
`endif

  // Handshake, write strobe and output data derived from current state/FIFO.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    // Full blocks the input even if a pop happens this cycle.
    in_ready_c = (state_q == S_RUN) && !fifo_full;
    push       = bus.in_valid && in_ready_c;
    pop        = active && !fifo_empty && bus.mem_ready;
    head       = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];

    bus.in_ready = in_ready_c;
    bus.wen      = pop;
    bus.waddr    = wr_cnt_q;
`ifdef RESULT_WRITER_BORDER_ZERO_EN
    row       = wr_cnt_q[ADDR_W-1:COL_W];
    col       = wr_cnt_q[COL_W-1:0];
    border    = (row == '0) || (row == '1) || (col == '0) || (col == '1);
    bus.wdata = border ? '0 : head;
`else
    bus.wdata = head;
`endif
    busy = active;
    done = (state_q == S_DONE);
  end

  // Next-state logic for the frame FSM and the accept/write counters.
  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    acc_term_d = acc_term_q;
    wr_cnt_d   = wr_cnt_q;
    wr_term_d  = wr_term_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          acc_cnt_d  = '0;
          acc_term_d = 1'b0;
          wr_cnt_d   = '0;
          wr_term_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (push) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_q == '1) begin
            acc_term_d = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (acc_term_q && wr_term_q && fifo_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // pop is only possible in RUN/DRAIN, never coincident with a start.
    if (pop) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '1) begin
        wr_term_d = 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and terminal-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q  <= '0;
      acc_term_q <= 1'b0;
      wr_cnt_q   <= '0;
      wr_term_q  <= 1'b0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      acc_term_q <= acc_term_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_term_q  <= wr_term_d;
    end
  end

  // FIFO control registers; reset empties the buffer and discards its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule
